// File: rtl/polar_bp_decoder.sv
// Polar-code belief-propagation decoder: one min-sum stage per clock over a column of N/2 PEs.
// Latency: k*n + (k-1)*(n-1) edges from start to done, k = iterations run (<= max_iter).
// Backpressure: none; start is only sampled while idle, a start during a decode is dropped.
module polar_bp_decoder #(
   parameter int N      = 8,
   parameter int BIT    = 8,
   parameter int ITER_W = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [N*BIT-1:0]  llr_in,
   input  logic [N-1:0]      frozen_mask,
   input  logic [ITER_W-1:0] max_iter,
   input  logic              early_stop_en,
   output logic              busy,
   output logic              done,
   output logic [N-1:0]      dec_bits,
   output logic [ITER_W-1:0] iter_count
);

   localparam int NS = $clog2(N);
   localparam int SW = (NS > 1) ? $clog2(NS) : 1;

   localparam logic signed [BIT-1:0] MAXV = {1'b0, {(BIT-1){1'b1}}};
   localparam logic signed [BIT:0]   MAXW = {2'b00, {(BIT-1){1'b1}}};
   localparam logic signed [BIT:0]   MINW = -MAXW;
   localparam logic signed [BIT-1:0] MOST_NEG = {1'b1, {(BIT-1){1'b0}}};

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LEFT  = 2'd1;
   localparam logic [1:0] S_RIGHT = 2'd2;

   // Add with clamp to +/-MAXV so the most negative code never appears.
   function automatic logic signed [BIT-1:0] sat_add(input logic signed [BIT-1:0] x,
                                                     input logic signed [BIT-1:0] y);
      logic signed [BIT:0] s;
      s = $signed({x[BIT-1], x}) + $signed({y[BIT-1], y});
      if (s > MAXW)      return MAXV;
      else if (s < MINW) return -MAXV;
      else               return s[BIT-1:0];
   endfunction

   // Min-sum check-node: sign(x)*sign(y)*min(|x|,|y|); inputs are never MOST_NEG.
   function automatic logic signed [BIT-1:0] fmin(input logic signed [BIT-1:0] x,
                                                  input logic signed [BIT-1:0] y);
      logic signed [BIT-1:0] ax, ay, m;
      ax = x[BIT-1] ? -x : x;
      ay = y[BIT-1] ? -y : y;
      m  = (ax < ay) ? ax : ay;
      return (x[BIT-1] ^ y[BIT-1]) ? -m : m;
   endfunction

   // Sign of the unsaturated sum, used for the hard decision.
   function automatic logic sum_neg(input logic signed [BIT-1:0] x,
                                    input logic signed [BIT-1:0] y);
      logic signed [BIT:0] s;
      s = $signed({x[BIT-1], x}) + $signed({y[BIT-1], y});
      return (s < 0);
   endfunction

   logic [1:0]           state_q, state_d;
   logic [SW-1:0]        stage_q, stage_d;
   logic [ITER_W-1:0]    k_q, k_d;
   logic [ITER_W-1:0]    kmax_q, kmax_d;
   logic [N-1:0]         fz_q, fz_d;
   logic                 es_q, es_d;
   logic [N-1:0]         dec_q, dec_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [N-1:0]         dec_bits_q, dec_bits_d;
   logic [ITER_W-1:0]    iter_q, iter_d;
   logic signed [BIT-1:0] l_q [N][NS+1];
   logic signed [BIT-1:0] l_d [N][NS+1];
   logic signed [BIT-1:0] r_q [N][NS+1];
   logic signed [BIT-1:0] r_d [N][NS+1];
   logic [N-1:0]         d_vec;
   logic                 fin;

   // Next-state: load on start, sweep left/right one stage per edge, decide after stage 0.
   always_comb begin
      state_d    = state_q;
      stage_d    = stage_q;
      k_d        = k_q;
      kmax_d     = kmax_q;
      fz_d       = fz_q;
      es_d       = es_q;
      dec_d      = dec_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      dec_bits_d = dec_bits_q;
      iter_d     = iter_q;
      l_d        = l_q;
      r_d        = r_q;
      d_vec      = '0;
      fin        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               for (int i = 0; i < N; i++) begin
                  for (int c = 0; c <= NS; c++) begin
                     l_d[i][c] = '0;
                     r_d[i][c] = '0;
                  end
                  l_d[i][NS] = (llr_in[i*BIT +: BIT] == MOST_NEG) ? -MAXV
                                                                : $signed(llr_in[i*BIT +: BIT]);
                  r_d[i][0]  = frozen_mask[i] ? MAXV : '0;
               end
               fz_d    = frozen_mask;
               es_d    = early_stop_en;
               kmax_d  = (max_iter == '0) ? ITER_W'(1) : max_iter;
               k_d     = ITER_W'(1);
               stage_d = SW'(NS-1);
               state_d = S_LEFT;
               busy_d  = 1'b1;
            end
         end
         S_LEFT: begin
            for (int s = 0; s < NS; s++) begin
               for (int a = 0; a < N; a++) begin
                  if (int'(stage_q) == s && ((a >> s) & 1) == 0) begin
                     l_d[a][s] = fmin(l_q[a][s+1],
                                      sat_add(l_q[a | (1 << s)][s+1], r_q[a | (1 << s)][s]));
                     l_d[a | (1 << s)][s] = sat_add(fmin(r_q[a][s], l_q[a][s+1]),
                                                    l_q[a | (1 << s)][s+1]);
                  end
               end
            end
            if (stage_q == '0) begin
               for (int i = 0; i < N; i++)
                  d_vec[i] = ~fz_q[i] & sum_neg(l_d[i][0], r_q[i][0]);
               dec_d = d_vec;
               fin   = (k_q == kmax_q) || (es_q && (k_q > ITER_W'(1)) && (d_vec == dec_q));
               if (fin) begin
                  state_d    = S_IDLE;
                  busy_d     = 1'b0;
                  done_d     = 1'b1;
                  dec_bits_d = d_vec;
                  iter_d     = k_q;
               end else begin
                  state_d = S_RIGHT;
                  stage_d = '0;
                  k_d     = k_q + ITER_W'(1);
               end
            end else begin
               stage_d = stage_q - SW'(1);
            end
         end
         S_RIGHT: begin
            for (int s = 0; s < NS - 1; s++) begin
               for (int a = 0; a < N; a++) begin
                  if (int'(stage_q) == s && ((a >> s) & 1) == 0) begin
                     r_d[a][s+1] = fmin(r_q[a][s],
                                        sat_add(l_q[a | (1 << s)][s+1], r_q[a | (1 << s)][s]));
                     r_d[a | (1 << s)][s+1] = sat_add(fmin(r_q[a][s], l_q[a][s+1]),
                                                      r_q[a | (1 << s)][s]);
                  end
               end
            end
            if (stage_q == SW'(NS-2)) begin
               state_d = S_LEFT;
               stage_d = SW'(NS-1);
            end else begin
               stage_d = stage_q + SW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset aborts any decode in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         stage_q    <= '0;
         k_q        <= '0;
         kmax_q     <= '0;
         fz_q       <= '0;
         es_q       <= 1'b0;
         dec_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         dec_bits_q <= '0;
         iter_q     <= '0;
         for (int i = 0; i < N; i++) begin
            for (int c = 0; c <= NS; c++) begin
               l_q[i][c] <= '0;
               r_q[i][c] <= '0;
            end
         end
      end else begin
         state_q    <= state_d;
         stage_q    <= stage_d;
         k_q        <= k_d;
         kmax_q     <= kmax_d;
         fz_q       <= fz_d;
         es_q       <= es_d;
         dec_q      <= dec_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         dec_bits_q <= dec_bits_d;
         iter_q     <= iter_d;
         l_q        <= l_d;
         r_q        <= r_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign dec_bits   = dec_bits_q;
   assign iter_count = iter_q;

endmodule

// File: tb/tb_polar_bp_decoder.sv
// Directed bench for polar_bp_decoder: an N=8 and an N=16 instance sharing clock and reset.
// Edge numbers are counted from the start edge E0; outputs are sampled 1 time unit after each edge.
// Expected values are hand-derived from the code structure and min-sum arithmetic.
module tb_polar_bp_decoder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        start8 = 1'b0;
   logic [63:0] llr8 = '0;
   logic [7:0]  mask8 = '0;
   logic [6:0]  kmax8 = '0;
   logic        es8 = 1'b0;
   logic        busy8, done8;
   logic [7:0]  dec8;
   logic [6:0]  it8;

   logic         start16 = 1'b0;
   logic [127:0] llr16 = '0;
   logic [15:0]  mask16 = '0;
   logic [6:0]   kmax16 = '0;
   logic         es16 = 1'b0;
   logic         busy16, done16;
   logic [15:0]  dec16;
   logic [6:0]   it16;

   int checks = 0;
   int errors = 0;

   polar_bp_decoder #(.N(8), .BIT(8), .ITER_W(7)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .llr_in(llr8), .frozen_mask(mask8),
      .max_iter(kmax8), .early_stop_en(es8), .busy(busy8), .done(done8),
      .dec_bits(dec8), .iter_count(it8));

   polar_bp_decoder #(.N(16), .BIT(8), .ITER_W(7)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .llr_in(llr16), .frozen_mask(mask16),
      .max_iter(kmax16), .early_stop_en(es16), .busy(busy16), .done(done16),
      .dec_bits(dec16), .iter_count(it16));

   localparam logic [63:0] LLR_POS = {8{8'h40}};
   localparam logic [63:0] LLR_CW  = 64'h40404040_C0C0C0C0;
   localparam logic [63:0] LLR_NEG = {8{8'h80}};

   // Drive inputs and a one-cycle start; returns 1 unit after the start edge E0.
   task automatic launch8(input logic [63:0] llr, input logic [7:0] mask,
                          input logic [6:0] k, input logic es);
      llr8 = llr; mask8 = mask; kmax8 = k; es8 = es; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
   endtask

   // Count edges until done; edge_no = -1 on timeout; busy_ok tracks busy high before done, low at done.
   task automatic wait_done8(output int edge_no, output bit busy_ok);
      busy_ok = 1'b1; edge_no = -1;
      for (int e = 0; e < 1000; e++) begin
         if (e > 0) begin @(posedge clk); #1; end
         if (done8) begin
            edge_no = e;
            if (busy8 !== 1'b0) busy_ok = 1'b0;
            break;
         end
         if (busy8 !== 1'b1) busy_ok = 1'b0;
      end
   endtask

   task automatic wait_done16(output int edge_no);
      edge_no = -1;
      for (int e = 0; e < 1000; e++) begin
         if (e > 0) begin @(posedge clk); #1; end
         if (done16) begin edge_no = e; break; end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL rst_busy8 got %b exp 0", busy8); end
      checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL rst_done8 got %b exp 0", done8); end
      checks++; if (dec8 !== 8'h00) begin errors++; $display("FAIL rst_dec8 got %h exp 00", dec8); end
      checks++; if (it8 !== 7'd0) begin errors++; $display("FAIL rst_iter8 got %0d exp 0", it8); end
      checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL rst_busy16 got %b exp 0", busy16); end
      checks++; if (dec16 !== 16'h0) begin errors++; $display("FAIL rst_dec16 got %h exp 0", dec16); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_loopback_es;
      int e; bit bok;
      launch8(LLR_POS, 8'b0001_0111, 7'd40, 1'b1);
      wait_done8(e, bok);
      checks++; if (e !== 8) begin errors++; $display("FAIL loop_edge got %0d exp 8", e); end
      checks++; if (dec8 !== 8'h00) begin errors++; $display("FAIL loop_dec got %h exp 00", dec8); end
      checks++; if (it8 !== 7'd2) begin errors++; $display("FAIL loop_iter got %0d exp 2", it8); end
      checks++; if (!bok) begin errors++; $display("FAIL loop_busy got bad exp high until done"); end
      @(posedge clk); #1;
      checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL loop_done_width got %b exp 0", done8); end
   endtask

   task automatic test_codeword_k40;
      int e; bit bok;
      launch8(LLR_CW, 8'b0001_0111, 7'd40, 1'b0);
      wait_done8(e, bok);
      checks++; if (e !== 198) begin errors++; $display("FAIL cw_edge got %0d exp 198", e); end
      checks++; if (dec8 !== 8'b0000_1000) begin errors++; $display("FAIL cw_dec got %b exp 00001000", dec8); end
      checks++; if (it8 !== 7'd40) begin errors++; $display("FAIL cw_iter got %0d exp 40", it8); end
      checks++; if (!bok) begin errors++; $display("FAIL cw_busy got bad exp high E0..E197"); end
   endtask

   task automatic test_iter_limit16;
      int e;
      llr16 = {16{8'h40}}; mask16 = '0; kmax16 = 7'd5; es16 = 1'b0; start16 = 1'b1;
      @(posedge clk); #1; start16 = 1'b0;
      wait_done16(e);
      checks++; if (e !== 32) begin errors++; $display("FAIL n16_k5_edge got %0d exp 32", e); end
      checks++; if (it16 !== 7'd5) begin errors++; $display("FAIL n16_k5_iter got %0d exp 5", it16); end
      kmax16 = 7'd0; start16 = 1'b1;
      @(posedge clk); #1; start16 = 1'b0;
      wait_done16(e);
      checks++; if (e !== 4) begin errors++; $display("FAIL n16_k0_edge got %0d exp 4", e); end
      checks++; if (it16 !== 7'd1) begin errors++; $display("FAIL n16_k0_iter got %0d exp 1", it16); end
   endtask

   // All -128 clamps to -127; one iteration gives u = all-ones * F^-1 = only u7 set.
   // Inputs are changed after E0 to show they are latched.
   task automatic test_saturation;
      int e; bit bok;
      launch8(LLR_NEG, 8'h00, 7'd1, 1'b0);
      llr8 = LLR_POS; mask8 = 8'hFF; kmax8 = 7'd40;
      wait_done8(e, bok);
      checks++; if (e !== 3) begin errors++; $display("FAIL sat_edge got %0d exp 3", e); end
      checks++; if (dec8 !== 8'b1000_0000) begin errors++; $display("FAIL sat_dec got %b exp 10000000", dec8); end
      checks++; if (it8 !== 7'd1) begin errors++; $display("FAIL sat_iter got %0d exp 1", it8); end
   endtask

   task automatic test_start_ignored;
      int dones = 0; int first = -1;
      launch8(LLR_POS, 8'b0001_0111, 7'd5, 1'b0);
      for (int e = 0; e <= 60; e++) begin
         if (e > 0) begin @(posedge clk); #1; end
         start8 = (e == 2);
         if (done8) begin dones++; if (first < 0) first = e; end
      end
      start8 = 1'b0;
      checks++; if (dones !== 1) begin errors++; $display("FAIL ign_count got %0d exp 1", dones); end
      checks++; if (first !== 23) begin errors++; $display("FAIL ign_edge got %0d exp 23", first); end
      checks++; if (it8 !== 7'd5) begin errors++; $display("FAIL ign_iter got %0d exp 5", it8); end
   endtask

   task automatic test_back_to_back;
      int e; bit bok;
      launch8(LLR_POS, 8'b0001_0111, 7'd40, 1'b1);
      wait_done8(e, bok);
      checks++; if (e !== 8) begin errors++; $display("FAIL b2b_first_edge got %0d exp 8", e); end
      launch8(LLR_CW, 8'b0001_0111, 7'd1, 1'b0);
      wait_done8(e, bok);
      checks++; if (e !== 3) begin errors++; $display("FAIL b2b_second_edge got %0d exp 3", e); end
      checks++; if (dec8 !== 8'b0000_1000) begin errors++; $display("FAIL b2b_dec got %b exp 00001000", dec8); end
      checks++; if (it8 !== 7'd1) begin errors++; $display("FAIL b2b_iter got %0d exp 1", it8); end
   endtask

   task automatic test_reset_abort;
      int e; bit bok; int seen = 0;
      launch8(LLR_CW, 8'b0001_0111, 7'd40, 1'b0);
      repeat (5) @(posedge clk);
      #1; rst_n = 1'b0; #1;
      checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy8); end
      checks++; if (dec8 !== 8'h00) begin errors++; $display("FAIL abort_dec got %h exp 00", dec8); end
      checks++; if (it8 !== 7'd0) begin errors++; $display("FAIL abort_iter got %0d exp 0", it8); end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (done8 !== 1'b0 || busy8 !== 1'b0) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles exp 0", seen); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      launch8(LLR_CW, 8'b0001_0111, 7'd1, 1'b0);
      wait_done8(e, bok);
      checks++; if (e !== 3) begin errors++; $display("FAIL post_rst_edge got %0d exp 3", e); end
      checks++; if (dec8 !== 8'b0000_1000) begin errors++; $display("FAIL post_rst_dec got %b exp 00001000", dec8); end
   endtask

   initial begin
      test_reset();
      test_loopback_es();
      test_codeword_k40();
      test_iter_limit16();
      test_saturation();
      test_start_ignored();
      test_back_to_back();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/polar_bp_decoder.md
# polar_bp_decoder

Parametrised belief-propagation decoder for polar codes of length N = 2^n. It sweeps one factor-graph stage per clock with a single column of N/2 min-sum processing elements, and adds runtime iteration limit, runtime frozen mask and early termination. It sits between the LLR front-end and the bit sink, using a start/done handshake.

## Interface
- N, 8, code length; power of two, 4..64; n = log2(N).
- BIT, 8, LLR width, signed two's complement.
- ITER_W, 7, width of max_iter and iter_count.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- llr_in  in  N*BIT  channel LLRs; slice i = LLR of x_i; positive means bit 0.
- frozen_mask  in  N  bit i = 1 marks u_i as frozen (value 0).
- max_iter  in  ITER_W  iteration limit K; 0 is treated as 1.
- early_stop_en  in  1  enables the stability stop.
- busy  out  1  high from the start edge until the done edge.
- done  out  1  one-cycle pulse when dec_bits is valid.
- dec_bits  out  N  decoded u; held until the next done.
- iter_count  out  ITER_W  iterations executed in the last decode.

## Operation
- Storage:
  - L[N][n+1] and R[N][n+1], each BIT wide. Column 0 is the u side; column n is the channel side.
  - Stage s (0..n-1) pairs (a, b = a+2^s) for every a with bit s = 0.
  - A PE at stage s reads R[.][s] and L[.][s+1].
- PE arithmetic (min-sum):
  - f(x,y) = sign(x)·sign(y)·min(|x|,|y|).
  - L_a = f(L'_a, L'_b + R_b); L_b = f(R_a, L'_a) + L'_b.
  - R_a = f(R_a, L'_b + R_b); R_b = f(R_a, L'_a) + R_b. Primed values are column s+1.
  - Every add saturates to ±(2^(BIT-1)-1). −2^(BIT-1) is never produced.
- Load, on the start edge:
  - L[.][n] = llr_in, with −2^(BIT-1) clamped to −(2^(BIT-1)-1).
  - R[i][0] = +max if frozen_mask[i], else 0.
  - All other cells = 0.
  - K, frozen_mask and early_stop_en are latched; later input changes are ignored.
- FSM: IDLE → LEFT (start) → RIGHT → LEFT … → IDLE.
  - LEFT: one edge per stage, s = n-1 down to 0, writing L[.][s] only.
  - RIGHT: one edge per stage, s = 0 up to n-2, writing R[.][s+1] only.
- Decision, taken on the edge that writes L[.][0] (end of iteration k):
  - d_i = 0 if frozen_mask[i], else (L_new[i][0] + R[i][0] < 0).
  - The decision register captures d.
  - Finish when k = K, or when early_stop_en && k ≥ 2 && d equals the previous decision.
  - Otherwise go to RIGHT.
- Finish edge:
  - dec_bits = d, iter_count = k, done = 1, busy = 0; return to IDLE.
- start while busy is ignored (no queueing).

## Timing
- Reset values: busy 0, done 0, dec_bits 0, iter_count 0; FSM in IDLE; decision register 0.
- Reset during a decode aborts immediately. No done is produced.
- Edge E0 is the start edge. One iteration costs n + (n-1) edges.
- done goes high after edge E(k·n + (k-1)·(n-1)).
  - N=8, K=40, no early stop: E198.
  - Minimum with early stop (k=2): E(3n-1).
- busy is high for cycles E0..E(last)-1. done is high for exactly one cycle.
- A start is accepted in the cycle right after done, so decodes run back-to-back.

## Test plan
- Loopback, N=8, frozen_mask=8'b0001_0111, llr all +64, early_stop_en=1, K=40 → dec_bits=0, iter_count=2, done at E8.
- Same mask, u3=1 so x=u·F^{⊗3}: llr[0..3]=−64, llr[4..7]=+64, early stop off, K=40 → dec_bits=8'b0000_1000, iter_count=40, done at E198, busy high E0..E197.
- N=16, K=5, early stop off, any LLRs → done at E32, iter_count=5. With K=0 → done at E4, iter_count=1.
- Saturation: every llr = −128 (BIT=8), all positions info → no wrap; dec_bits matches a golden model with clamp at ±127.
- start pulsed at E3 mid-decode → ignored, single done. rst_n low at E5, then start → clean decode, outputs 0 during reset.
